pq_insert_arb: RTL

- Round-robin scheduler that shares one hardware priority queue among N_REQ inserting requesters and one remover.
- Sits between the requesters and the PQ device. Drives the PQ client-side signals (ivalid/idata/ordy) and observes irdy/busy/full/ovalid/odata.
- Has a 1-entry capture register, so each requester sees a simple valid/ready handshake.
- Inserts and removes are mutually exclusive at the PQ boundary; a pending insert wins.

---
 rtl/pq_insert_arb_pkg.sv | 16 +
 rtl/pq_insert_arb_if.sv | 39 +++
 rtl/pq_insert_arb_rr_pick.sv | 23 ++
 rtl/pq_insert_arb.sv | 109 ++++++++++
 4 files changed

// File: rtl/pq_insert_arb_pkg.sv
// Shared types for the priority-queue insert arbiter: key/value item, FSM state, defaults.
package pq_insert_arb_pkg;

  localparam int unsigned PQ_ARB_NREQ_DEF = 4;

  typedef struct packed {
    logic [15:0] key;
    logic [15:0] val;
  } kv_t;

  typedef enum logic {
    StIdle,
    StOffer
  } arb_state_e;

endpackage

// File: rtl/pq_insert_arb_if.sv
// Requester, remover and PQ client-side signals of the insert arbiter.
interface pq_insert_arb_if
  import pq_insert_arb_pkg::*;
#(
  parameter int unsigned N_REQ = PQ_ARB_NREQ_DEF
) ();

  logic [N_REQ-1:0] req_ivalid;
  logic [N_REQ-1:0] req_irdy;
  kv_t  [N_REQ-1:0] req_idata;

  logic rm_ordy;
  logic rm_ovalid;
  kv_t  rm_odata;

  logic pq_ivalid;
  logic pq_irdy;
  kv_t  pq_idata;
  logic pq_busy;
  logic pq_full;
  logic pq_ovalid;
  logic pq_ordy;
  kv_t  pq_odata;

  modport master (
    input  req_ivalid, req_idata, rm_ordy,
    input  pq_irdy, pq_busy, pq_full, pq_ovalid, pq_odata,
    output req_irdy, rm_ovalid, rm_odata,
    output pq_ivalid, pq_idata, pq_ordy
  );

  modport slave (
    output req_ivalid, req_idata, rm_ordy,
    output pq_irdy, pq_busy, pq_full, pq_ovalid, pq_odata,
    input  req_irdy, rm_ovalid, rm_odata,
    input  pq_ivalid, pq_idata, pq_ordy
  );

endinterface

// File: rtl/pq_insert_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after last_gnt_i, cyclic.
module pq_insert_arb_rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned GNT_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [GNT_W-1:0] last_gnt_i,
  output logic             any_o,
  output logic [GNT_W-1:0] idx_o
);

  always_comb begin
    int unsigned j;
    any_o = |req_i;
    idx_o = '0;
    // Walk from farthest to nearest so the nearest hit is written last and wins.
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      j = (32'(last_gnt_i) + k) % N_REQ;
      if (req_i[j]) idx_o = GNT_W'(j);
    end
  end

endmodule

// File: rtl/pq_insert_arb.sv
// Round-robin insert arbiter in front of one priority queue; removes stall while an insert is
// pending. Optional grant counters are built when PQ_ARB_STATS_EN is defined.
module pq_insert_arb
  import pq_insert_arb_pkg::*;
#(
  parameter  int unsigned N_REQ  = PQ_ARB_NREQ_DEF,
`ifdef PQ_ARB_STATS_EN
  parameter  int unsigned STAT_W = 16,
`endif
  localparam int unsigned GNT_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  pq_insert_arb_if.master  bus,
  output logic [GNT_W-1:0] gnt_idx
`ifdef PQ_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][STAT_W-1:0] stat_cnt
`endif
);

  arb_state_e       state_q, state_d;
  kv_t              hold_q, hold_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic [GNT_W-1:0] last_q, last_d;
  logic             pick_any;
  logic [GNT_W-1:0] pick_idx;
  logic             capture;
  logic             rm_ovalid;

  // Busy is informational only; offers wait for pq_irdy alone.
  logic unused_busy;
  assign unused_busy = bus.pq_busy;

  pq_insert_arb_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_i      (bus.req_ivalid),
    .last_gnt_i (last_q),
    .any_o      (pick_any),
    .idx_o      (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    capture      = 1'b0;
    bus.req_irdy = '0;
    unique case (state_q)
      StIdle:  capture = pick_any && !bus.pq_full;
      StOffer: begin
        if (bus.pq_irdy) begin
          state_d = StIdle;
          capture = pick_any && !bus.pq_full;
        end
      end
    endcase
    if (capture) begin
      state_d                = StOffer;
      hold_d                 = bus.req_idata[pick_idx];
      gnt_d                  = pick_idx;
      last_d                 = pick_idx;
      bus.req_irdy[pick_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
      gnt_q   <= '0;
      last_q  <= GNT_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign bus.pq_ivalid = (state_q == StOffer);
  assign bus.pq_idata  = hold_q;
  assign rm_ovalid     = bus.pq_ovalid && (state_q == StIdle);
  assign bus.rm_ovalid = rm_ovalid;
  assign bus.pq_ordy   = bus.rm_ordy && rm_ovalid;
  assign bus.rm_odata  = bus.pq_odata;
  assign gnt_idx       = gnt_q;

`ifdef PQ_ARB_STATS_EN
  logic [N_REQ-1:0][STAT_W-1:0] stat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (capture && (32'(pick_idx) == i) && (stat_q[i] != '1)) begin
          stat_q[i] <= stat_q[i] + STAT_W'(1);
        end
      end
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule
